// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_store_unit                                                  |
// | Brief   : Single-outstanding load/store bridge between the core datapath   |
// |           and a req/ack memory bus. Little-endian byte lanes and           |
// |           sign/zero extension of loads. Optional macro                     |
// |           LSU_ALIGN_CHECK_EN traps misaligned half/word accesses.          |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_valid,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_done   = 2'd2;

  logic [1:0]  r_state;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic [29:0] r_word_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;
  logic        r_misalign;
  logic        r_discard;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_discard;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Lane enables and replicated store data from the incoming request
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = core_wdata;
    case (core_size)
      2'b00: begin
        w_be    = 4'b0001 << core_addr[1:0];
        w_wdata = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = core_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{core_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ((core_size == 2'b01) && core_addr[0]) ||
                      (core_size[1] && (core_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Load lane selection and extension from the captured access attributes
  always_comb begin
    case (r_addr_lo)
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      2'd3:    w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  // A core that drops its request mid-access no longer wants the result
  assign w_discard = r_discard | ~core_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_idle;
      r_we          <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= 2'b00;
      r_addr_lo     <= 2'b00;
      r_word_addr   <= 30'd0;
      r_be          <= 4'b0000;
      r_wdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_misalign    <= 1'b0;
      case (r_state)
        c_idle: begin
          if (core_valid) begin
            r_we        <= core_we;
            r_unsigned  <= core_unsigned;
            r_size      <= core_size;
            r_addr_lo   <= core_addr[1:0];
            r_word_addr <= core_addr[31:2];
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_discard   <= 1'b0;
            if (w_misalign) begin
              r_state    <= c_done;
              r_misalign <= 1'b1;
            end else begin
              r_state    <= c_access;
            end
          end
        end
        c_access: begin
          if (!core_valid) r_discard <= 1'b1;
          if (bus_ack) begin
            r_state <= c_done;
            if (!r_we && !w_discard) begin
              r_rdata       <= w_load;
              r_rdata_valid <= 1'b1;
            end
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign stall       = core_valid & (r_state != c_done);
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign misalign    = r_misalign;
  assign bus_req     = (r_state == c_access);
  assign bus_we      = r_we;
  assign bus_addr    = {r_word_addr, 2'b00};
  assign bus_be      = r_be;
  assign bus_wdata   = r_wdata;

endmodule
`default_nettype wire
